// File: rtl/hazard_pkg.sv
// Shared types, RV32I opcode constants and the per-source forwarding resolver
// for the hazard/forwarding unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_EX  = 2'd3
    } fwd_sel_e;

    typedef enum logic [1:0] {
        WB_PC4  = 2'd0,
        WB_ALU  = 2'd1,
        WB_LSU  = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       alu_cls;
    } sb_entry_t;

    localparam int SB_W = $bits(sb_entry_t);

    typedef struct packed {
        logic     haz;
        fwd_sel_e sel;
    } fwd_res_t;

    function automatic logic uses_rs1(input logic [6:0] opc);
        return !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return opc inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    endfunction

    // Youngest producer wins; a non-ALU result still in EX or MEM is not ready yet.
    function automatic fwd_res_t resolve_src(
        input logic       used,
        input logic [4:0] rs,
        input sb_entry_t  ex,
        input sb_entry_t  mem,
        input logic       wb_vld,
        input logic [4:0] wb_rd
    );
        fwd_res_t res;
        res.haz = 1'b0;
        res.sel = FWD_RF;
        if (used && (rs != 5'd0)) begin
            if (ex.vld && (ex.rd == rs)) begin
                if (ex.alu_cls) res.sel = FWD_EX;
                else            res.haz = 1'b1;
            end else if (mem.vld && (mem.rd == rs)) begin
                if (mem.alu_cls) res.sel = FWD_MEM;
                else             res.haz = 1'b1;
            end else if (wb_vld && (wb_rd == rs)) begin
                res.sel = FWD_WB;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot shadow scoreboard (EX, MEM, WB) that shifts every unfrozen cycle
// and inserts a bubble into EX on a stall or flush.
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_freeze,
    input  logic            i_bubble,
    input  logic [SB_W-1:0] i_id_entry,
    output logic [SB_W-1:0] o_ex,
    output logic [SB_W-1:0] o_mem,
    output logic [SB_W-1:0] o_wb
);

    sb_entry_t ex_q, ex_d;
    sb_entry_t mem_q, mem_d;
    sb_entry_t wb_q, wb_d;

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path leaves it unassigned and infers a latch.
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!i_freeze) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (i_bubble) ex_d = '0;
            else          ex_d = sb_entry_t'(i_id_entry);
        end
    end

    // NOTE: non-blocking so all slots shift on the same edge using their pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign o_ex  = ex_q;
    assign o_mem = mem_q;
    assign o_wb  = wb_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding control for the 5-stage RV32I pipeline.
// Define HAZARD_PERF_CNT_EN to build the stall/flush counters; otherwise both read 0.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [31:0]      instr_id,
    input  logic             rd_wren,
    input  logic [1:0]       wb_sel,
    input  logic             pc_sel_ex,
    input  logic             i_stall_ext,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_id,
    output logic             flush_ex,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd_id;
    sb_entry_t  id_entry, sb_ex, sb_mem, sb_wb;
    fwd_res_t   res_a, res_b;
    logic       hazard;
    logic       unused_bits;

    assign opcode = instr_id[6:0];
    assign rd_id  = instr_id[11:7];
    assign rs1    = instr_id[19:15];
    assign rs2    = instr_id[24:20];

    always_comb begin
        id_entry.vld     = rd_wren & (rd_id != 5'd0);
        id_entry.rd      = rd_id;
        id_entry.alu_cls = (wb_sel == WB_ALU);
    end

    hazard_scoreboard u_sb (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_freeze   (i_stall_ext),
        .i_bubble   (stall_id | flush_ex),
        .i_id_entry (id_entry),
        .o_ex       (sb_ex),
        .o_mem      (sb_mem),
        .o_wb       (sb_wb)
    );

    // A flush wins over a hazard stall: the ID instruction is on the wrong path.
    always_comb begin
        res_a     = resolve_src(uses_rs1(opcode), rs1, sb_ex, sb_mem, sb_wb.vld, sb_wb.rd);
        res_b     = resolve_src(uses_rs2(opcode), rs2, sb_ex, sb_mem, sb_wb.vld, sb_wb.rd);
        hazard    = res_a.haz | res_b.haz;
        flush_ex  = pc_sel_ex & ~i_stall_ext;
        flush_id  = flush_ex;
        stall_id  = hazard & ~pc_sel_ex & ~i_stall_ext;
        stall_if  = stall_id;
        forward_a = hazard ? FWD_RF : res_a.sel;
        forward_b = hazard ? FWD_RF : res_b.sel;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Both strobes are already masked by the freeze, so the counters hold then.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_id && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_ex && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

    assign unused_bits = ^{instr_id[31:25], instr_id[14:12], sb_wb.alu_cls};

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed scenarios plus randomized
// traffic against an in-flight instruction list model.
module tb_hazard_fwd_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] FENCE  = 7'b0001111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    logic             i_clk = 1'b0;
    logic             i_reset, rd_wren, pc_sel_ex, i_stall_ext;
    logic [31:0]      instr_id;
    logic [1:0]       wb_sel, forward_a, forward_b;
    logic             stall_if, stall_id, flush_id, flush_ex;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    hazard_fwd_unit #(.CNT_W(CNT_W)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .instr_id    (instr_id),
        .rd_wren     (rd_wren),
        .wb_sel      (wb_sel),
        .pc_sel_ex   (pc_sel_ex),
        .i_stall_ext (i_stall_ext),
        .forward_a   (forward_a),
        .forward_b   (forward_b),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .flush_id    (flush_id),
        .flush_ex    (flush_ex),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: list of producers in flight, index 0 = youngest (in EX).
    typedef struct {
        bit vld;
        int rd;
        bit alu;
    } ent_t;

    ent_t pipe[$];
    int   m_sc, m_fc;
    int   e_fa, e_fb;
    bit   e_haz, e_stall, e_flush, e_fchk;

    function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b0, 5'(rd), op};
    endfunction

    function automatic void model_clear();
        ent_t z;
        z.vld = 0; z.rd = 0; z.alu = 0;
        pipe.delete();
        repeat (3) pipe.push_back(z);
        m_sc = 0;
        m_fc = 0;
    endfunction

    function automatic void src_lookup(input int rs, output int sel, output bit haz);
        sel = 0;
        haz = 0;
        if (rs == 0) return;
        foreach (pipe[i]) begin
            if (pipe[i].vld && pipe[i].rd == rs) begin
                if (i == 2)           sel = 1;
                else if (pipe[i].alu) sel = 3 - i;
                else                  haz = 1;
                return;
            end
        end
    endfunction

    function automatic void model_eval();
        logic [6:0] op;
        bit u1, u2, h1, h2;
        int s1, s2;
        op = instr_id[6:0];
        u1 = !(op inside {LUI, AUIPC, JAL});
        u2 = op inside {OP, STORE, BRANCH};
        src_lookup(u1 ? int'(instr_id[19:15]) : 0, s1, h1);
        src_lookup(u2 ? int'(instr_id[24:20]) : 0, s2, h2);
        e_haz   = h1 || h2;
        e_flush = pc_sel_ex && !i_stall_ext;
        e_stall = e_haz && !pc_sel_ex && !i_stall_ext;
        e_fa    = e_stall ? 0 : s1;
        e_fb    = e_stall ? 0 : s2;
        e_fchk  = !e_haz || e_stall;
    endfunction

    task automatic tick();
        ent_t n;
        model_eval();
        @(posedge i_clk);
        if (i_reset) begin
            model_clear();
        end else if (!i_stall_ext) begin
            n.vld = !(e_stall || e_flush) && rd_wren && (instr_id[11:7] != 5'd0);
            n.rd  = int'(instr_id[11:7]);
            n.alu = (wb_sel == 2'b01);
            pipe.push_front(n);
            void'(pipe.pop_back());
            if (e_stall && m_sc < CNT_MAX) m_sc++;
            if (e_flush && m_fc < CNT_MAX) m_fc++;
        end
        #1;
    endtask

    task automatic present(input logic [6:0] op, input int rd, input int rs1, input int rs2,
                           input logic wren, input logic [1:0] wb);
        instr_id = enc(op, rd, rs1, rs2);
        rd_wren  = wren;
        wb_sel   = wb;
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input int rd, input int rs1, input int rs2, input logic [1:0] wb);
        present(op, rd, rs1, rs2, 1'b1, wb);
        tick();
    endtask

    task automatic do_reset();
        i_reset = 1'b1; pc_sel_ex = 1'b0; i_stall_ext = 1'b0;
        present(FENCE, 0, 0, 0, 1'b0, 2'b00);
        tick();
        i_reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; pc_sel_ex = 1'b0; i_stall_ext = 1'b0;
        present(OP, 7, 6, 6, 1'b1, 2'b01);
        tick();
        i_reset = 1'b0;
        #1;
        n_vec++;
        if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b0000) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 0000", {stall_if, stall_id, flush_id, flush_ex});
        end
        n_vec++;
        if ({forward_a, forward_b} !== 4'b0000) begin
            n_err++; $display("FAIL reset_fwd: got %b want 0000", {forward_a, forward_b});
        end
        n_vec++;
        if ({stall_cnt, flush_cnt} !== '0) begin
            n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_ex_alu_fwd();
        do_reset();
        issue(OP, 5, 1, 2, 2'b01);
        present(OP, 7, 5, 1, 1'b1, 2'b01);
        n_vec++;
        if ({forward_a, forward_b, stall_id, stall_if} !== {2'd3, 2'd0, 2'b00}) begin
            n_err++; $display("FAIL ex_fwd_a: got fa=%0d fb=%0d st=%b want fa=3 fb=0 st=0", forward_a, forward_b, stall_id);
        end
        present(OP, 7, 1, 5, 1'b1, 2'b01);
        n_vec++;
        if ({forward_a, forward_b, stall_id} !== {2'd0, 2'd3, 1'b0}) begin
            n_err++; $display("FAIL ex_fwd_b: got fa=%0d fb=%0d st=%b want fa=0 fb=3 st=0", forward_a, forward_b, stall_id);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        issue(LOAD, 6, 1, 0, 2'b10);
        present(OP, 7, 6, 6, 1'b1, 2'b01);
        for (int c = 0; c < 2; c++) begin
            n_vec++;
            if ({stall_if, stall_id, flush_id, flush_ex, forward_a, forward_b} !== 8'b1100_0000) begin
                n_err++; $display("FAIL load_use_stall%0d: got %b want 11000000", c,
                                  {stall_if, stall_id, flush_id, flush_ex, forward_a, forward_b});
            end
            tick();
        end
        n_vec++;
        if ({stall_id, forward_a, forward_b} !== {1'b0, 2'd1, 2'd1}) begin
            n_err++; $display("FAIL load_use_release: got st=%b fa=%0d fb=%0d want st=0 fa=1 fb=1", stall_id, forward_a, forward_b);
        end
        present(OP, 9, 7, 7, 1'b1, 2'b01);
        n_vec++;
        if ({stall_id, forward_a, forward_b} !== 5'b0) begin
            n_err++; $display("FAIL load_use_bubbles: got st=%b fa=%0d fb=%0d want all 0", stall_id, forward_a, forward_b);
        end
        present(OP, 7, 6, 6, 1'b1, 2'b01);
        tick();
        n_vec++;
        if ({stall_cnt, flush_cnt} !== {(PERF ? 4'd2 : 4'd0), 4'd0}) begin
            n_err++; $display("FAIL load_use_cnt: got %0d/%0d want %0d/0", stall_cnt, flush_cnt, PERF ? 2 : 0);
        end
    endtask

    task automatic test_x0_and_unused();
        do_reset();
        issue(OPIMM, 0, 3, 0, 2'b10);
        present(OP, 1, 0, 0, 1'b1, 2'b01);
        n_vec++;
        if ({stall_id, forward_a, forward_b} !== 5'b0) begin
            n_err++; $display("FAIL x0_read: got st=%b fa=%0d fb=%0d want all 0", stall_id, forward_a, forward_b);
        end
        present(LOAD, 3, 0, 0, 1'b0, 2'b10);
        tick();
        present(OP, 1, 3, 3, 1'b1, 2'b01);
        n_vec++;
        if ({stall_id, forward_a, forward_b} !== 5'b0) begin
            n_err++; $display("FAIL no_wren: got st=%b fa=%0d fb=%0d want all 0", stall_id, forward_a, forward_b);
        end
        issue(LOAD, 4, 0, 0, 2'b10);
        present(LUI, 1, 4, 4, 1'b1, 2'b01);
        n_vec++;
        if (stall_id !== 1'b0) begin n_err++; $display("FAIL lui_no_stall: got %b want 0", stall_id); end
        present(OPIMM, 1, 0, 4, 1'b1, 2'b01);
        n_vec++;
        if (stall_id !== 1'b0) begin n_err++; $display("FAIL opimm_rs2_unused: got %b want 0", stall_id); end
        present(JAL, 1, 4, 4, 1'b1, 2'b00);
        n_vec++;
        if (stall_id !== 1'b0) begin n_err++; $display("FAIL jal_no_stall: got %b want 0", stall_id); end
        present(STORE, 0, 0, 4, 1'b0, 2'b00);
        n_vec++;
        if (stall_id !== 1'b1) begin n_err++; $display("FAIL store_rs2_stall: got %b want 1", stall_id); end
        present(JALR, 1, 4, 0, 1'b1, 2'b00);
        n_vec++;
        if (stall_id !== 1'b1) begin n_err++; $display("FAIL jalr_rs1_stall: got %b want 1", stall_id); end
    endtask

    task automatic test_priority();
        int exp_fb[4] = '{3, 2, 1, 0};
        do_reset();
        issue(OPIMM, 8, 1, 0, 2'b01);
        issue(OPIMM, 8, 8, 0, 2'b01);
        present(OP, 9, 0, 8, 1'b0, 2'b01);
        for (int c = 0; c < 4; c++) begin
            n_vec++;
            if ({stall_id, forward_a, forward_b} !== {1'b0, 2'd0, 2'(exp_fb[c])}) begin
                n_err++; $display("FAIL priority%0d: got st=%b fa=%0d fb=%0d want st=0 fa=0 fb=%0d",
                                  c, stall_id, forward_a, forward_b, exp_fb[c]);
            end
            tick();
        end
    endtask

    task automatic test_flush_over_stall();
        do_reset();
        issue(LOAD, 6, 1, 0, 2'b10);
        present(OP, 7, 6, 6, 1'b1, 2'b01);
        pc_sel_ex = 1'b1;
        #1;
        n_vec++;
        if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b0011) begin
            n_err++; $display("FAIL flush_wins: got %b want 0011", {stall_if, stall_id, flush_id, flush_ex});
        end
        tick();
        pc_sel_ex = 1'b0;
        present(OP, 9, 7, 7, 1'b1, 2'b01);
        n_vec++;
        if ({stall_id, forward_a, forward_b} !== 5'b0) begin
            n_err++; $display("FAIL flush_bubble: got st=%b fa=%0d fb=%0d want all 0", stall_id, forward_a, forward_b);
        end
        present(OP, 7, 6, 6, 1'b1, 2'b01);
        n_vec++;
        if (stall_id !== 1'b1) begin n_err++; $display("FAIL flush_mem_load: got %b want 1", stall_id); end
        n_vec++;
        if ({stall_cnt, flush_cnt} !== {4'd0, (PERF ? 4'd1 : 4'd0)}) begin
            n_err++; $display("FAIL flush_cnt: got %0d/%0d want 0/%0d", stall_cnt, flush_cnt, PERF ? 1 : 0);
        end
    endtask

    task automatic test_ext_freeze();
        do_reset();
        issue(LOAD, 6, 1, 0, 2'b10);
        present(OP, 7, 6, 6, 1'b1, 2'b01);
        tick();
        i_stall_ext = 1'b1;
        for (int c = 0; c < 3; c++) begin
            pc_sel_ex = (c == 1);
            #1;
            n_vec++;
            if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b0000) begin
                n_err++; $display("FAIL freeze_ctrl%0d: got %b want 0000", c, {stall_if, stall_id, flush_id, flush_ex});
            end
            n_vec++;
            if ({stall_cnt, flush_cnt} !== {(PERF ? 4'd1 : 4'd0), 4'd0}) begin
                n_err++; $display("FAIL freeze_cnt%0d: got %0d/%0d want %0d/0", c, stall_cnt, flush_cnt, PERF ? 1 : 0);
            end
            tick();
        end
        i_stall_ext = 1'b0;
        pc_sel_ex   = 1'b0;
        #1;
        n_vec++;
        if (stall_id !== 1'b1) begin n_err++; $display("FAIL freeze_resume: got %b want 1", stall_id); end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        #1;
        n_vec++;
        if ({stall_if, stall_id, flush_id, flush_ex, forward_a, forward_b, stall_cnt, flush_cnt} !== '0) begin
            n_err++; $display("FAIL reset_mid_stall: got ctrl=%b fa=%0d fb=%0d cnt=%0d/%0d want all 0",
                              {stall_if, stall_id, flush_id, flush_ex}, forward_a, forward_b, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        present(FENCE, 0, 0, 0, 1'b0, 2'b00);
        pc_sel_ex = 1'b1;
        repeat (20) tick();
        pc_sel_ex = 1'b0;
        #1;
        n_vec++;
        if (flush_cnt !== (PERF ? 4'd15 : 4'd0)) begin
            n_err++; $display("FAIL flush_cnt_sat: got %0d want %0d", flush_cnt, PERF ? 15 : 0);
        end
    endtask

    task automatic test_random();
        logic [6:0] opc_tbl[12] = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, FENCE, SYSTEM, 7'b1111111};
        do_reset();
        for (int c = 0; c < 600; c++) begin
            i_reset     = ($urandom_range(0, 96) == 0);
            pc_sel_ex   = ($urandom_range(0, 7) == 0);
            i_stall_ext = ($urandom_range(0, 7) == 0);
            present(opc_tbl[$urandom_range(0, 11)], $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
            model_eval();
            n_vec++;
            if ({stall_if, stall_id, flush_id, flush_ex} !== {e_stall, e_stall, e_flush, e_flush}) begin
                n_err++; $display("FAIL rnd_ctrl@%0d: got %b want %b", c,
                                  {stall_if, stall_id, flush_id, flush_ex}, {e_stall, e_stall, e_flush, e_flush});
            end
            if (e_fchk) begin
                n_vec++;
                if ({forward_a, forward_b} !== {2'(e_fa), 2'(e_fb)}) begin
                    n_err++; $display("FAIL rnd_fwd@%0d: got fa=%0d fb=%0d want fa=%0d fb=%0d",
                                      c, forward_a, forward_b, e_fa, e_fb);
                end
            end
            n_vec++;
            if ({stall_cnt, flush_cnt} !== {CNT_W'(PERF ? m_sc : 0), CNT_W'(PERF ? m_fc : 0)}) begin
                n_err++; $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d", c, stall_cnt, flush_cnt,
                                  PERF ? m_sc : 0, PERF ? m_fc : 0);
            end
            tick();
        end
        i_reset = 1'b0; pc_sel_ex = 1'b0; i_stall_ext = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_ex_alu_fwd();
        test_load_use();
        test_x0_and_unused();
        test_priority();
        test_flush_over_stall();
        test_ext_freeze();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Hazard-detection and forwarding-control unit for the 5-stage RV32I pipeline; it produces the `forward_a`/`forward_b` selects that the decode stage's operand muxes consume, plus the stall and flush controls for IF/ID/EX. It tracks the destination register, write-enable and result class of the instructions in EX, MEM and WB in its own shadow scoreboard. Each cycle it compares those against the rs1/rs2 of the instruction in ID. It resolves load/PC+4 use hazards by stalling and resolves taken control transfers by flushing.

## Interface
- `CNT_W`, default 32: width of the performance counters.
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `instr_id` in 32: instruction currently in ID.
- `rd_wren` in 1: ID-stage control-unit write enable for `instr_id`.
- `wb_sel` in 2: ID-stage writeback select: 00 = PC+4, 01 = ALU, 10 = LSU, 11 = reserved (treated as LSU).
- `pc_sel_ex` in 1: a taken branch or jump is resolved in EX this cycle.
- `i_stall_ext` in 1: external pipeline freeze (memory wait).
- `forward_a`, `forward_b` out 2: operand select: 0 = regfile, 1 = `wb_data`, 2 = `alu_data_mem`, 3 = `alu_data`.
- `stall_if`, `stall_id` out 1: hold PC and the IF/ID register.
- `flush_id`, `flush_ex` out 1: turn the IF/ID and ID/EX registers into bubbles.
- `stall_cnt`, `flush_cnt` out `CNT_W`: performance counters (see Configuration).

## Operation
- **Scoreboard.** Three slots: EX, MEM and WB. Each slot holds `{vld, rd[4:0], alu_cls}`. `alu_cls` = 1 only when `wb_sel` == 01.
- **Scoreboard update.** On each clock edge, if `i_stall_ext` = 0:
  - WB←MEM and MEM←EX.
  - EX← the ID entry, where `vld = rd_wren & rd != 0`.
  - If `stall_id` or `flush_ex` is asserted, the EX entry is instead loaded with a bubble (`vld` = 0).
  - If `i_stall_ext` = 1, all slots hold their values.
- **Source usage**, decoded from `instr_id[6:0]`:
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used only by OP, STORE and BRANCH.
  - An unused source gets forward 0 and can never cause a stall.
- **Forwarding**, per source rs (rs != 0). Match = slot `vld` & slot `rd` == rs. Priority is EX > MEM > WB:
  - EX match with `alu_cls` → 3. EX match without `alu_cls` → hazard.
  - Otherwise MEM match with `alu_cls` → 2. MEM match without `alu_cls` → hazard.
  - Otherwise WB match → 1.
  - Otherwise → 0.
- **Hazard stall.** Any hazard on a used source sets `stall_if` = `stall_id` = 1. Forward outputs are don't-care during a stall, but are driven to 0.
  - Load/PC+4 producer in EX: stall lasts 2 cycles, then forward 1.
  - Same producer in MEM: stall lasts 1 cycle.
- **Flush.** `pc_sel_ex` = 1 → `flush_id` = `flush_ex` = 1. A flush overrides a hazard stall: `stall_if`/`stall_id` = 0 that cycle, because the ID instruction is on the wrong path.
- **External freeze.** `i_stall_ext` = 1 suppresses `flush_*` and hazard `stall_*`. The pipeline is frozen and no state changes.
- Outputs are a function of the current state and the current inputs only. There is no other internal state.

## Timing
- `forward_*`, `stall_*` and `flush_*` are combinational from the inputs and the scoreboard, valid in the same cycle. There is no added latency.
- The scoreboard changes one cycle after the ID entry is presented.
- Reset, including mid-stall:
  - All slots `vld` = 0 and counters = 0 on the next edge.
  - With `pc_sel_ex` = 0, all outputs are 0 from that edge on.
- **Counters.** `stall_cnt` increments on each edge where `stall_id` = 1; `flush_cnt` increments on each edge where `flush_ex` = 1. Both saturate at 2^`CNT_W`−1 and hold during `i_stall_ext`.

## Configuration
- `HAZARD_PERF_CNT_EN`:
  - Defined: `stall_cnt` and `flush_cnt` are implemented as above.
  - Undefined: no counter flops exist, both ports are tied to 0, and all other behaviour is identical.

## Structure
- Package `hazard_pkg` holds:
  - enum `fwd_sel_e` (`FWD_RF`, `FWD_WB`, `FWD_MEM`, `FWD_EX`);
  - enum `wb_sel_e`;
  - RV32I opcode constants;
  - the slot struct `sb_entry_t`.
- Sub-module `hazard_scoreboard` holds the three-slot shift register with bubble insertion and freeze. Comparison and priority logic stay in the top module.

## Test plan
- `add x5` (`wb_sel`=01) in EX, then ID `sub x7,x5,x1` → `forward_a`=3, `forward_b`=0, no stall.
- `lw x6` (`wb_sel`=10) in EX, then ID `add x7,x6,x6` → `stall_id`=1 for exactly 2 cycles, then `forward_a`=`forward_b`=1 with no stall; EX receives 2 bubbles.
- Producer `rd`=x0 with `rd_wren`=1, then ID reads x0 → forward 0, no stall. LUI in ID with an EX match on bits[19:15] → no stall.
- EX `addi x8` and MEM `addi x8` both valid, then ID reads x8 on rs2 → `forward_b`=3. Remove the EX entry → `forward_b`=2.
- Load-use stall active and `pc_sel_ex`=1 → `flush_id`=`flush_ex`=1, `stall_id`=0; next cycle EX slot `vld`=0. With `HAZARD_PERF_CNT_EN`, `flush_cnt`=1.
- `i_stall_ext`=1 for 3 cycles mid-stall → scoreboard and counters frozen, no flush; then `i_reset`=1 for one cycle → all outputs 0 and counters 0 after the edge.
